// File: rtl/reg_file_scoreboard.sv
// Register file with write-through bypass and a per-register pending-write
// scoreboard, tracking issued-but-not-written-back destinations.
module reg_file_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    logic wr_hit;
    logic iss_hit;

    assign wr_hit  = wr_en && (wr_addr != '0);
    assign iss_hit = iss_en && (iss_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    // Order matters: flush, then writeback clear, then issue set, so a new
    // producer on the same edge always leaves its register marked busy.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        if (wr_hit) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (iss_hit) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Outputs are gated by rst so the bypass path cannot leak wr_data during reset.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              byp;
        logic              iss_tgt;

        assign ra      = rd_addr[k*ADDR_W +: ADDR_W];
        assign byp     = wr_hit && (wr_addr == ra);
        assign iss_tgt = iss_hit && (iss_addr == ra);

        assign rd_data[k*DATA_W +: DATA_W] = !rst ? '0 : (byp ? wr_data : regs_q[ra]);
        assign rd_busy[k] = rst && busy_q[ra] && !(byp && !iss_tgt);
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: directed vector table, reset/flush sequences,
// and randomized traffic against an array-based reference model.
module tb_reg_file_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             flush;
    logic [AW:0]      busy_cnt;

    reg_file_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_reg  [32];
    bit            m_busy [32];

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ie;
        logic [AW-1:0] ia;
        logic          fl;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;
        logic [DW-1:0] e_rd0;
        logic          e_bz0;
        logic [DW-1:0] e_rd1;
        int            e_cnt;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0;
        iss_en = 0; iss_addr = '0; flush = 0; rd_addr = '0;
    endtask

    // Called just after a rising edge; applies one cycle of inputs, checks the
    // combinational outputs and the registered count against the model.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic ie, input logic [AW-1:0] ia, input logic fl,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                        output logic [DW-1:0] c_rd0, output logic c_bz0,
                        output logic [DW-1:0] c_rd1);
        logic [AW-1:0] ra;
        logic          byp, itg;
        wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; flush = fl;
        rd_addr = {r1, r0};
        #3;
        for (int k = 0; k < NR; k++) begin
            ra  = (k == 0) ? r0 : r1;
            byp = we && (wa != 0) && (wa == ra);
            itg = ie && (ia != 0) && (ia == ra);
            chk($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], byp ? wd : m_reg[ra]);
            chk($sformatf("rd_busy%0d", k), 32'(rd_busy[k]), 32'(m_busy[ra] && !(byp && !itg)));
        end
        c_rd0 = rd_data[DW-1:0];
        c_bz0 = rd_busy[0];
        c_rd1 = rd_data[2*DW-1:DW];
        @(posedge clk);
        if (fl) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        if (we && wa != 0) begin
            m_reg[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (ie && ia != 0) m_busy[ia] = 1'b1;
        #1;
        chk("busy_cnt_model", 32'(busy_cnt), 32'(m_cnt()));
    endtask

    logic [DW-1:0] c_rd0, c_rd1;
    logic          c_bz0;

    initial begin
        tbl[0]  = '{1'b1, 5'd1, 32'hF0F0F0F0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd1, 32'hF0F0F0F0, 1'b0, 32'hF0F0F0F0, 0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd1, 5'd1, 32'hF0F0F0F0, 1'b0, 32'hF0F0F0F0, 0};
        tbl[2]  = '{1'b1, 5'd0, 32'hF0F0F0F0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1, 32'h0,        1'b0, 32'hF0F0F0F0, 0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b0, 5'd5, 5'd1, 32'h0,        1'b0, 32'hF0F0F0F0, 1};
        tbl[4]  = '{1'b1, 5'd5, 32'h0F0F0F0F, 1'b0, 5'd0, 1'b0, 5'd5, 5'd1, 32'h0F0F0F0F, 1'b0, 32'hF0F0F0F0, 0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd1, 32'h0F0F0F0F, 1'b0, 32'hF0F0F0F0, 0};
        tbl[6]  = '{1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b0, 5'd7, 5'd1, 32'h12345678, 1'b0, 32'hF0F0F0F0, 1};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd1, 32'h12345678, 1'b1, 32'hF0F0F0F0, 1};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b0, 5'd0, 5'd1, 32'h0,        1'b0, 32'hF0F0F0F0, 1};
        tbl[9]  = '{1'b1, 5'd7, 32'hAAAA5555, 1'b0, 5'd0, 1'b0, 5'd7, 5'd5, 32'hAAAA5555, 1'b0, 32'h0F0F0F0F, 0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 5'd9, 5'd7, 32'h0,        1'b0, 32'hAAAA5555, 1};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 5'd9, 5'd1, 32'h0,        1'b1, 32'hF0F0F0F0, 1};
        tbl[12] = '{1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 1'b0, 5'd3, 5'd1, 32'h00000033, 1'b0, 32'hF0F0F0F0, 1};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd9, 5'd3, 32'h0,        1'b1, 32'h00000033, 0};

        // Reset held: outputs zero for every address, strobes ignored across edges.
        m_clear();
        idle_inputs();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            wr_en = 1; wr_addr = 5'(a); wr_data = 32'hFFFFFFFF;
            iss_en = 1; iss_addr = 5'(a); flush = a[0];
            rd_addr = {5'(a), 5'(a)};
            #2;
            chk("rst_rd_data", rd_data[DW-1:0] | rd_data[2*DW-1:DW], 32'h0);
            chk("rst_rd_busy", 32'(rd_busy), 32'h0);
            chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].ia, tbl[i].fl,
                 tbl[i].r0, tbl[i].r1, c_rd0, c_bz0, c_rd1);
            chk($sformatf("tbl%0d_rd0", i), c_rd0, tbl[i].e_rd0);
            chk($sformatf("tbl%0d_bz0", i), 32'(c_bz0), 32'(tbl[i].e_bz0));
            chk($sformatf("tbl%0d_rd1", i), c_rd1, tbl[i].e_rd1);
            chk($sformatf("tbl%0d_cnt", i), 32'(busy_cnt), 32'(tbl[i].e_cnt));
        end

        // Fill every busy bit, then flush with a same-edge issue to 3.
        for (int a = 1; a < 32; a++) step(0, 0, 0, 1, 5'(a), 0, 0, 0, c_rd0, c_bz0, c_rd1);
        chk("fill_cnt", 32'(busy_cnt), 32'd31);
        step(0, 0, 0, 1, 5'd3, 1, 5'd3, 5'd9, c_rd0, c_bz0, c_rd1);
        chk("flush_cnt", 32'(busy_cnt), 32'd1);
        step(0, 0, 0, 0, 0, 0, 5'd1, 5'd3, c_rd0, c_bz0, c_rd1);
        chk("flush_r1_data", c_rd0, 32'hF0F0F0F0);
        chk("flush_r1_busy", 32'(c_bz0), 32'd0);
        chk("flush_r3_busy", 32'(rd_busy[1]), 32'd1);
        chk("flush_r3_data", c_rd1, 32'h00000033);

        // Asynchronous reset between edges with the scoreboard full.
        for (int a = 1; a < 32; a++) step(0, 0, 0, 1, 5'(a), 0, 0, 0, c_rd0, c_bz0, c_rd1);
        chk("refill_cnt", 32'(busy_cnt), 32'd31);
        wr_en = 1; wr_addr = 5'd1; wr_data = 32'h55555555; rd_addr = {5'd31, 5'd1};
        #2;
        rst = 1'b0;
        #1;
        m_clear();
        chk("async_cnt", 32'(busy_cnt), 32'd0);
        chk("async_rd_data", rd_data[DW-1:0] | rd_data[2*DW-1:DW], 32'h0);
        chk("async_rd_busy", 32'(rd_busy), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1, 5'd31, 32'hDEADBEEF, 0, 0, 0, 5'd31, 5'd1, c_rd0, c_bz0, c_rd1);
        chk("r31_bypass", c_rd0, 32'hDEADBEEF);
        chk("r1_cleared", c_rd1, 32'h0);
        step(0, 0, 0, 0, 0, 0, 5'd31, 5'd31, c_rd0, c_bz0, c_rd1);
        chk("r31_read", c_rd0, 32'hDEADBEEF);
        chk("r31_busy", 32'(c_bz0), 32'd0);

        // Randomized traffic with addresses biased toward collisions.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wa, ia, r0, r1;
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ia = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            r0 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom);
            r1 = ($urandom_range(0, 2) == 0) ? ia : 5'($urandom_range(0, 7));
            step(1'($urandom), wa, $urandom, 1'($urandom), ia, ($urandom_range(0, 15) == 0),
                 r0, r1, c_rd0, c_bz0, c_rd1);
        end

        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving depth 2**ADDR_W registers.
REQ-003 The block SHALL have parameter NUM_RD, default 2, the number of independent read ports (1..4).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit; one clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have port wr_en, input, 1 bit, the writeback strobe.
REQ-007 The block SHALL have port wr_addr, input, ADDR_W bits, the writeback register index.
REQ-008 The block SHALL have port wr_data, input, DATA_W bits, the writeback value.
REQ-009 The block SHALL have port rd_addr, input, NUM_RD*ADDR_W bits; port k index is in slice [k*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port rd_data, output, NUM_RD*DATA_W bits; port k value is in slice [k*DATA_W +: DATA_W].
REQ-011 The block SHALL have port rd_busy, output, NUM_RD bits; bit k is the pending-write flag of rd_addr port k.
REQ-012 The block SHALL have port iss_en, input, 1 bit, the strobe marking an instruction issue with a destination register.
REQ-013 The block SHALL have port iss_addr, input, ADDR_W bits, the destination register of the issuing instruction.
REQ-014 The block SHALL have port flush, input, 1 bit, a synchronous clear of all busy bits.
REQ-015 The block SHALL have port busy_cnt, output, ADDR_W+1 bits, the number of registers currently busy.

Function
REQ-016 Register 0 SHALL always read 0, ignore writes, and never become busy.
REQ-017 On a rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data.
REQ-018 Reads SHALL be combinational; rd_data port k = reg[rd_addr k].
REQ-019 Write-through bypass: if wr_en=1, wr_addr!=0 and rd_addr k==wr_addr, rd_data port k SHALL equal wr_data in that same cycle.
REQ-020 Busy set: on an edge with iss_en=1 and iss_addr!=0, busy[iss_addr] SHALL be 1 afterwards.
REQ-021 Busy clear: on an edge with wr_en=1 and wr_addr!=0, busy[wr_addr] SHALL be 0 afterwards, unless REQ-022 applies.
REQ-022 If iss_en and wr_en target the same nonzero address on the same edge, busy SHALL end set (new producer wins); data SHALL still be written.
REQ-023 rd_busy bit k SHALL be busy[rd_addr k] combinationally, except it SHALL read 0 when a same-cycle writeback to that address bypasses per REQ-019 and no same-cycle issue targets it.
REQ-024 flush=1 on an edge SHALL clear every busy bit; an iss_en on the same edge SHALL still set its bit; register data SHALL be unaffected.
REQ-025 busy_cnt SHALL be a registered count equal to the popcount of busy bits after each edge, range 0..2**ADDR_W-1, never wrapping.
REQ-026 Writeback to a non-busy register SHALL be legal, write data, and leave busy_cnt unchanged.
REQ-027 Repeated issue to an already-busy register SHALL leave busy_cnt unchanged.

Reset
REQ-028 While rst=0, all registers, all busy bits and busy_cnt SHALL be 0 immediately, without waiting for clk.
REQ-029 While rst=0, rd_data SHALL read all zeros and rd_busy SHALL read all zeros for any address; wr_en, iss_en and flush SHALL be ignored.
REQ-030 On release of rst, the first rising edge SHALL operate normally.

Verification
REQ-031 Hold rst=0, sweep rd_addr 0..31 on all ports -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-032 wr_en=1, wr_addr=1, wr_data=F0F0F0F0, rd_addr0=1 -> rd_data0=F0F0F0F0 in the same cycle (bypass) and after the edge; write to addr 0 with the same data -> rd_data0=0.
REQ-033 iss_en addr 5 -> rd_busy=1 on a port reading 5, busy_cnt=1; next cycle wr_en addr 5 data 0F0F0F0F -> rd_busy=0 in that cycle, data 0F0F0F0F, busy_cnt=0 after the edge.
REQ-034 Same edge iss_en and wr_en to addr 7 -> data written, busy[7]=1, busy_cnt increments by 1; iss_en to addr 0 -> busy_cnt unchanged.
REQ-035 Issue to addrs 1..31 -> busy_cnt=31; flush with iss_en addr 3 -> busy_cnt=1, only 3 busy, data intact.
REQ-036 Assert rst=0 mid-sequence, between edges, with busy_cnt=31 -> all outputs 0 immediately; after release, write/read of R31 behaves normally.
